// File: rtl/contador_bcd_barrido.sv
// Two-digit BCD counter with prescaled tick, programmable wrap and a display-scan generator.
// Define CUENTA_REGRESIVA_EN to add the up_dn port and down-counting with borrow wrap.
module contador_bcd_barrido #(
  parameter int unsigned PRESCALE  = 50_000_000,
  parameter int unsigned SCAN_DIV  = 50_000,
  parameter int unsigned MAX_COUNT = 59
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       clr,
  input  logic       cargar,
  input  logic [7:0] dato_carga,
`ifdef CUENTA_REGRESIVA_EN
  input  logic       up_dn,
`endif
  output logic [3:0] D1,
  output logic [3:0] D0,
  output logic       Seleccion,
  output logic [1:0] anodo,
  output logic       acarreo
);

  localparam logic [31:0] PRE_LAST  = 32'(PRESCALE - 1);
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);
  localparam logic [3:0]  MAX_T     = 4'(MAX_COUNT / 10);
  localparam logic [3:0]  MAX_U     = 4'(MAX_COUNT % 10);

  logic [31:0] presc_reg, presc_next;
  logic [31:0] scan_reg;
  logic        sel_reg;
  logic [3:0]  d1_reg, d1_next;
  logic [3:0]  d0_reg, d0_next;
  logic        carry_reg, carry_next;
  logic        tick;
  logic        load_ok;
  logic        count_up;
  logic [3:0]  load_t, load_u;

`ifdef CUENTA_REGRESIVA_EN
  assign count_up = up_dn;
`else
  assign count_up = 1'b1;
`endif

  assign load_t = dato_carga[7:4];
  assign load_u = dato_carga[3:0];
  // Both nibbles must be BCD and the value must not exceed the wrap point.
  assign load_ok = (load_t <= 4'd9) && (load_u <= 4'd9) &&
                   ((load_t < MAX_T) || ((load_t == MAX_T) && (load_u <= MAX_U)));

  assign tick = en && (presc_reg == PRE_LAST);

  always_comb begin
    presc_next = presc_reg;
    if (clr) begin
      presc_next = '0;
    end else if (cargar && load_ok) begin
      presc_next = '0;
    end else if (en) begin
      presc_next = tick ? '0 : presc_reg + 32'd1;
    end
  end

  always_comb begin
    d1_next    = d1_reg;
    d0_next    = d0_reg;
    carry_next = 1'b0;
    if (clr) begin
      d1_next = '0;
      d0_next = '0;
    end else if (cargar) begin
      if (load_ok) begin
        d1_next = load_t;
        d0_next = load_u;
      end
    end else if (tick) begin
      if (count_up) begin
        if ((d1_reg == MAX_T) && (d0_reg == MAX_U)) begin
          d1_next    = '0;
          d0_next    = '0;
          carry_next = 1'b1;
        end else if (d0_reg == 4'd9) begin
          d0_next = '0;
          d1_next = d1_reg + 4'd1;
        end else begin
          d0_next = d0_reg + 4'd1;
        end
      end else begin
        if ((d1_reg == 4'd0) && (d0_reg == 4'd0)) begin
          d1_next    = MAX_T;
          d0_next    = MAX_U;
          carry_next = 1'b1;
        end else if (d0_reg == 4'd0) begin
          d0_next = 4'd9;
          d1_next = d1_reg - 4'd1;
        end else begin
          d0_next = d0_reg - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
      d1_reg    <= '0;
      d0_reg    <= '0;
      carry_reg <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      d1_reg    <= d1_next;
      d0_reg    <= d0_next;
      carry_reg <= carry_next;
    end
  end

  // Scan runs free of en/clr/cargar so the display never freezes on one digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_reg <= '0;
      sel_reg  <= 1'b0;
    end else if (scan_reg == SCAN_LAST) begin
      scan_reg <= '0;
      sel_reg  <= ~sel_reg;
    end else begin
      scan_reg <= scan_reg + 32'd1;
    end
  end

  assign D1        = d1_reg;
  assign D0        = d0_reg;
  assign Seleccion = sel_reg;
  assign anodo     = sel_reg ? 2'b01 : 2'b10;
  assign acarreo   = carry_reg;

endmodule
